// File: rtl/ofc_pkg.sv
// ---------------------------------------------------------------------------
// ofc_pkg
//  Shared constants and types for the package ring memory. The write side
//  (write_control) and the read side (read_control) both import this so the
//  ring geometry is defined in exactly one place.
//
//  Contents:
//    PKG_LEN    words per package
//    MEM_DEPTH  ring RAM depth in words
//    ADDR_W     RAM address width
//    N_CH/CH_W  channel count and channel width of one RAM word
//    DATA_W     RAM word width (N_CH * CH_W, channel 0 in the LSBs)
//    MAX_PKG    whole packages that fit in the ring at once
//    wc_state_t write-side FSM states
// ---------------------------------------------------------------------------
package ofc_pkg;

  localparam int PKG_LEN   = 518;
  localparam int MEM_DEPTH = 24576;
  localparam int ADDR_W    = 15;
  localparam int N_CH      = 16;
  localparam int CH_W      = 16;
  localparam int DATA_W    = N_CH * CH_W;

  // Elaboration-time division only; no divider is ever built from this.
  localparam int MAX_PKG   = MEM_DEPTH / PKG_LEN;

  // Counter widths used on the write side.
  localparam int WCNT_W    = 10;
  localparam int NPKG_W    = 6;
  localparam int DROP_W    = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wc_state_t;

endpackage

// File: rtl/ring_addr_inc.sv
// ---------------------------------------------------------------------------
// ring_addr_inc
//  Combinational ring-address step: result = (addr + step) mod DEPTH.
//  Both operands are assumed to be below DEPTH, so the sum is below
//  2*DEPTH and a single compare-and-subtract replaces the modulo.
//
//  Ports:
//    addr    in   AW  current address (< DEPTH)
//    step    in   AW  increment (< DEPTH)
//    result  out  AW  wrapped address
// ---------------------------------------------------------------------------
module ring_addr_inc
  import ofc_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] step,
  output logic [AW-1:0] result
);

  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  // One extra bit so the raw sum never overflows before the compare.
  logic [AW:0] sum;
  logic [AW:0] sum_wrapped;

  always_comb begin
    sum         = {1'b0, addr} + {1'b0, step};
    sum_wrapped = sum - DEPTH_EXT;
    if (sum >= DEPTH_EXT) begin
      result = sum_wrapped[AW-1:0];
    end else begin
      result = sum[AW-1:0];
    end
  end

endmodule

// File: rtl/write_control.sv
// ---------------------------------------------------------------------------
// write_control
//  Producer side of the package ring memory. A trigger starts a package of
//  PACKAGE_LENGTH words taken from the sample stream (only cycles with
//  din_valid count) and written to consecutive ring addresses, wrapping at
//  MEMORY_DEPTH. The last write of a package pulses read_start on the same
//  edge as its wen, advances the package base and bumps the stored-package
//  count. Triggers that arrive while a package is being written, or while
//  the ring already holds MAX packages, are dropped and counted.
//
//  Ports:
//    clk           in   1           system clock
//    rst           in   1           asynchronous active-high reset
//    live_rising   in   1           synchronous clear, same effect as rst
//    trigger       in   1           start-of-package request (pulse)
//    din_valid     in   1           din carries a sample word this cycle
//    din           in   DATA_WIDTH  sample word
//    pkg_done      in   1           read side released one package (pulse)
//    wen           out  1           RAM write enable (registered)
//    waddr         out  ADDR_W      RAM write address (registered)
//    wdata         out  DATA_WIDTH  RAM write data (registered)
//    read_start    out  1           package committed (pulse)
//    n_pkg_stored  out  NPKG_W      packages written and not yet released
//    busy          out  1           high while in WRITE
//    drop_cnt      out  DROP_W      dropped triggers, saturating
// ---------------------------------------------------------------------------
module write_control
  import ofc_pkg::*;
#(
  parameter int PACKAGE_LENGTH = PKG_LEN,
  parameter int MEMORY_DEPTH   = MEM_DEPTH,
  parameter int DATA_WIDTH     = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  live_rising,
  input  logic                  trigger,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pkg_done,
  output logic                  wen,
  output logic [ADDR_W-1:0]     waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  read_start,
  output logic [NPKG_W-1:0]     n_pkg_stored,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int               MAX_PACKAGES = MEMORY_DEPTH / PACKAGE_LENGTH;
  localparam logic [NPKG_W-1:0] MAX_NPKG    = NPKG_W'(MAX_PACKAGES);
  localparam logic [WCNT_W-1:0] LAST_WORD   = WCNT_W'(PACKAGE_LENGTH - 1);
  localparam logic [ADDR_W-1:0] STEP_WORD   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP_PKG    = ADDR_W'(PACKAGE_LENGTH);

  // -------------------------------------------------------------------------
  // State and counters
  // -------------------------------------------------------------------------
  wc_state_t           state_reg;
  logic [ADDR_W-1:0]   base_addr_reg;   // start address of the next package
  logic [ADDR_W-1:0]   wptr_reg;        // address of the next word to write
  logic [WCNT_W-1:0]   wcnt_reg;        // words written in current package

  logic [ADDR_W-1:0]   wptr_next;
  logic [ADDR_W-1:0]   base_addr_next;

  // -------------------------------------------------------------------------
  // Ring address arithmetic
  // -------------------------------------------------------------------------
  ring_addr_inc #(
    .DEPTH (MEMORY_DEPTH),
    .AW    (ADDR_W)
  ) u_wptr_inc (
    .addr   (wptr_reg),
    .step   (STEP_WORD),
    .result (wptr_next)
  );

  ring_addr_inc #(
    .DEPTH (MEMORY_DEPTH),
    .AW    (ADDR_W)
  ) u_base_inc (
    .addr   (base_addr_reg),
    .step   (STEP_PKG),
    .result (base_addr_next)
  );

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic ring_full;
  logic trig_accept;
  logic trig_drop;
  logic do_write;
  logic pkg_complete;
  logic pkg_release;

  always_comb begin
    ring_full    = (n_pkg_stored >= MAX_NPKG);
    trig_accept  = trigger && (state_reg == IDLE) && !ring_full;
    // Everything that is not an accept is a drop: busy writing, or full.
    trig_drop    = trigger && ((state_reg == WRITE) || ring_full);
    do_write     = (state_reg == WRITE) && din_valid;
    pkg_complete = do_write && (wcnt_reg == LAST_WORD);
    // A release with nothing stored is ignored so the count cannot underflow.
    pkg_release  = pkg_done && (n_pkg_stored != '0);
  end

  assign busy = (state_reg == WRITE);

  // -------------------------------------------------------------------------
  // FSM, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_addr_reg <= '0;
      wptr_reg      <= '0;
      wcnt_reg      <= '0;
      wen           <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      read_start    <= 1'b0;
      n_pkg_stored  <= '0;
      drop_cnt      <= '0;
    end else if (live_rising) begin
      // Same clear as rst; a package in flight is abandoned without read_start.
      state_reg     <= IDLE;
      base_addr_reg <= '0;
      wptr_reg      <= '0;
      wcnt_reg      <= '0;
      wen           <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      read_start    <= 1'b0;
      n_pkg_stored  <= '0;
      drop_cnt      <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      wen        <= 1'b0;
      read_start <= 1'b0;

      if (trig_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      // Completion and release in the same cycle cancel out.
      case ({pkg_complete, pkg_release})
        2'b10:   n_pkg_stored <= n_pkg_stored + 1'b1;
        2'b01:   n_pkg_stored <= n_pkg_stored - 1'b1;
        default: n_pkg_stored <= n_pkg_stored;
      endcase

      case (state_reg)
        IDLE: begin
          if (trig_accept) begin
            wcnt_reg  <= '0;
            wptr_reg  <= base_addr_reg;
            state_reg <= WRITE;
          end
        end

        WRITE: begin
          if (din_valid) begin
            wen      <= 1'b1;
            waddr    <= wptr_reg;
            wdata    <= din;
            wptr_reg <= wptr_next;
            wcnt_reg <= wcnt_reg + 1'b1;
            if (pkg_complete) begin
              // read_start rides on the same edge as the final wen.
              read_start    <= 1'b1;
              base_addr_reg <= base_addr_next;
              state_reg     <= IDLE;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
